dispatch_scoreboard: RTL and testbench

Parametrised in-order dispatch stage between the control unit and the scalar functional units (arith, mult, div, lsu, csr/jump).
- Buffers decoded control words in a DEPTH-entry FIFO.
- Tracks outstanding register writes in a 32-entry scoreboard.
- Issues the queue head to exactly one of NUM_FU functional units once RAW/WAW hazards clear and the target unit is ready.
- Unlike a purely combinational decode interface, it decouples decode from multi-cycle units.

---
 rtl/dispatch_scoreboard_if.sv | 41 ++++
 rtl/dispatch_scoreboard.sv | 149 ++++++++++++++
 tb/tb_dispatch_scoreboard.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_scoreboard_if.sv
// Bundle of enqueue, issue, writeback and status signals for dispatch_scoreboard.
// master: control unit / functional-unit side; slave: the dispatch stage itself.
interface dispatch_scoreboard_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NUM_FU = 5,
    parameter int unsigned CTRL_W = 64
);
    localparam int unsigned FuW  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic                  enq_valid;
    logic                  enq_ready;
    logic [CTRL_W-1:0]     enq_ctrl;
    logic [FuW-1:0]        enq_fu;
    logic [4:0]            enq_rs1;
    logic [4:0]            enq_rs2;
    logic [4:0]            enq_rd;
    logic                  enq_wen;
    logic                  flush;
    logic [NUM_FU-1:0]     iss_valid;
    logic [NUM_FU-1:0]     iss_ready;
    logic [CTRL_W-1:0]     iss_ctrl;
    logic [4:0]            iss_rd;
    logic [NUM_FU-1:0]     wb_valid;
    logic [NUM_FU*5-1:0]   wb_rd;
    logic [31:0]           busy;
    logic [CntW-1:0]       count;
    logic                  stall_hazard;

    modport master (
        output enq_valid, enq_ctrl, enq_fu, enq_rs1, enq_rs2, enq_rd, enq_wen, flush,
        output iss_ready, wb_valid, wb_rd,
        input  enq_ready, iss_valid, iss_ctrl, iss_rd, busy, count, stall_hazard
    );

    modport slave (
        input  enq_valid, enq_ctrl, enq_fu, enq_rs1, enq_rs2, enq_rd, enq_wen, flush,
        input  iss_ready, wb_valid, wb_rd,
        output enq_ready, iss_valid, iss_ctrl, iss_rd, busy, count, stall_hazard
    );
endinterface

// File: rtl/dispatch_scoreboard.sv
// In-order dispatch queue with a 32-entry register scoreboard gating RAW/WAW hazards.
// Optional feature: define SCOREBOARD_WB_BYPASS_EN to let same-cycle writebacks release hazards.
module dispatch_scoreboard #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NUM_FU = 5,
    parameter int unsigned CTRL_W = 64
) (
    input logic                 CLK,
    input logic                 RST,
    dispatch_scoreboard_if.slave bus
);
    localparam int unsigned FuW  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [FuW-1:0]    fu;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              wen;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [31:0]       busy_q, busy_d;

    entry_t            head;
    entry_t            enq_entry;
    logic [31:0]       wb_hit;
    logic [31:0]       busy_eff;
    logic              empty, full;
    logic              haz_rs1, haz_rs2, haz_waw, hazard;
    logic              issuable, push, pop;
    logic [NUM_FU-1:0] iss_valid;

    // Registers named by any completing lane this cycle; duplicates collapse to one clear.
    always_comb begin
        wb_hit = '0;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            if (bus.wb_valid[i]) begin
                wb_hit[bus.wb_rd[5*i +: 5]] = 1'b1;
            end
        end
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign busy_eff = busy_q & ~wb_hit;
`else
    assign busy_eff = busy_q;
`endif

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));

    always_comb begin
        haz_rs1  = (head.rs1 != 5'd0) && busy_eff[head.rs1];
        haz_rs2  = (head.rs2 != 5'd0) && busy_eff[head.rs2];
        haz_waw  = head.wen && (head.rd != 5'd0) && busy_eff[head.rd];
        hazard   = haz_rs1 || haz_rs2 || haz_waw;
        issuable = !empty && !bus.flush && !hazard;
    end

    always_comb begin
        iss_valid = '0;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            iss_valid[i] = issuable && (head.fu == FuW'(i));
        end
    end

    assign pop  = |(iss_valid & bus.iss_ready);
    assign push = bus.enq_valid && !full && !bus.flush;

    always_comb begin
        enq_entry.ctrl = bus.enq_ctrl;
        enq_entry.fu   = bus.enq_fu;
        enq_entry.rs1  = bus.enq_rs1;
        enq_entry.rs2  = bus.enq_rs2;
        enq_entry.rd   = bus.enq_rd;
        enq_entry.wen  = bus.enq_wen;
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = enq_entry;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Flush leaves busy alone: already-issued writers still complete.
    always_comb begin
        busy_d = busy_q & ~wb_hit;
        if (pop && head.wen && (head.rd != 5'd0)) begin
            busy_d[head.rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.enq_ready    = !full;
    assign bus.iss_valid    = iss_valid;
    assign bus.iss_ctrl     = head.ctrl;
    assign bus.iss_rd       = head.rd;
    assign bus.busy         = busy_q;
    assign bus.count        = count_q;
    assign bus.stall_hazard = !empty && !bus.flush && hazard;

endmodule

// File: tb/tb_dispatch_scoreboard.sv
// Directed bench for dispatch_scoreboard; expectations follow SCOREBOARD_WB_BYPASS_EN if defined.
module tb_dispatch_scoreboard;
    logic CLK;
    logic RST;
    int   n_tests;
    int   n_fail;

    dispatch_scoreboard_if #(.DEPTH(4), .NUM_FU(5), .CTRL_W(64)) bus ();

    dispatch_scoreboard #(.DEPTH(4), .NUM_FU(5), .CTRL_W(64)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic enq(input logic v, input logic [2:0] fu, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic wen,
                       input logic [63:0] ctrl);
        bus.enq_valid = v;
        bus.enq_fu    = fu;
        bus.enq_rs1   = rs1;
        bus.enq_rs2   = rs2;
        bus.enq_rd    = rd;
        bus.enq_wen   = wen;
        bus.enq_ctrl  = ctrl;
    endtask

    task automatic wb_add(input int lane, input logic [4:0] rd);
        bus.wb_valid[lane]     = 1'b1;
        bus.wb_rd[5*lane +: 5] = rd;
    endtask

    task automatic wb_clear();
        bus.wb_valid = '0;
        bus.wb_rd    = '0;
    endtask

    logic [63:0] exp_head [7];
    logic [2:0]  exp_cnt  [7];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST = 1'b1;
        enq(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        bus.flush     = 1'b0;
        bus.iss_ready = '0;
        wb_clear();
        #1;
        check("rst_count", bus.count, 0);
        check("rst_enq_ready", bus.enq_ready, 1);
        check("rst_iss_valid", bus.iss_valid, 0);
        check("rst_stall", bus.stall_hazard, 0);
        check("rst_busy", bus.busy, 0);
        tick();
        tick();
        RST = 1'b0;

        // Single ADD x3 <- x1, x2 on fu 0
        bus.iss_ready = 5'b11111;
        enq(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1, 64'hA1);
        #1;
        check("add_no_passthru", bus.iss_valid, 0);
        tick();
        enq(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        #1;
        check("add_count1", bus.count, 1);
        check("add_iss_valid", bus.iss_valid, 5'b00001);
        check("add_iss_ctrl", bus.iss_ctrl, 64'hA1);
        check("add_iss_rd", bus.iss_rd, 3);
        tick();
        check("add_busy3", bus.busy, 32'h8);
        check("add_count0", bus.count, 0);
        check("add_iss_idle", bus.iss_valid, 0);
        wb_add(0, 5'd3);
        tick();
        wb_clear();
        #1;
        check("add_wb_clear", bus.busy, 0);

        // RAW: producer x5 on fu 2, consumer reads x5 on fu 0
        enq(1'b1, 3'd2, 5'd0, 5'd0, 5'd5, 1'b1, 64'h50);
        tick();
        enq(1'b1, 3'd0, 5'd5, 5'd0, 5'd6, 1'b1, 64'h60);
        #1;
        check("raw_prod_issue", bus.iss_valid, 5'b00100);
        tick();
        enq(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        #1;
        check("raw_stall", bus.stall_hazard, 1);
        check("raw_blocked", bus.iss_valid, 0);
        check("raw_busy5", bus.busy, 32'h20);
        check("raw_count", bus.count, 1);
        check("raw_head_ctrl", bus.iss_ctrl, 64'h60);
        tick();
        check("raw_still_stall", bus.stall_hazard, 1);
        wb_add(2, 5'd5);
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        check("raw_wb_issue", bus.iss_valid, 5'b00001);
        check("raw_wb_stall", bus.stall_hazard, 0);
        tick();
        wb_clear();
        #1;
        check("raw_busy_after", bus.busy, 32'h40);
        check("raw_count_after", bus.count, 0);
`else
        check("raw_wb_issue", bus.iss_valid, 0);
        check("raw_wb_stall", bus.stall_hazard, 1);
        tick();
        wb_clear();
        #1;
        check("raw_busy_clear", bus.busy, 0);
        check("raw_issue_late", bus.iss_valid, 5'b00001);
        check("raw_count_late", bus.count, 1);
        tick();
        check("raw_busy_after", bus.busy, 32'h40);
        check("raw_count_after", bus.count, 0);
`endif
        wb_add(0, 5'd6);
        tick();
        wb_clear();
        #1;
        check("raw_wb6", bus.busy, 0);

        // x0 writes never set busy; x0 readers never stall
        enq(1'b1, 3'd1, 5'd0, 5'd0, 5'd0, 1'b1, 64'h01);
        tick();
        enq(1'b1, 3'd3, 5'd0, 5'd0, 5'd0, 1'b0, 64'h02);
        #1;
        check("x0_write_issue", bus.iss_valid, 5'b00010);
        tick();
        enq(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        #1;
        check("x0_busy", bus.busy, 0);
        check("x0_reader_issue", bus.iss_valid, 5'b01000);
        check("x0_reader_stall", bus.stall_hazard, 0);
        tick();
        check("x0_drained", bus.count, 0);

        // Fill with no ready unit, then stream with fu 0 ready
        bus.iss_ready = '0;
        for (int i = 0; i < 4; i++) begin
            enq(1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h10 + 64'(i));
            tick();
        end
        check("fill_count", bus.count, 4);
        check("fill_enq_ready", bus.enq_ready, 0);
        check("fill_iss_valid", bus.iss_valid, 5'b00001);
        check("fill_head", bus.iss_ctrl, 64'h10);
        exp_head = '{64'h10, 64'h11, 64'h12, 64'h13, 64'h21, 64'h22, 64'h23};
        exp_cnt  = '{3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
        bus.iss_ready = 5'b00001;
        for (int k = 0; k < 7; k++) begin
            enq(1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h20 + 64'(k));
            #1;
            check($sformatf("stream_head%0d", k), bus.iss_ctrl, exp_head[k]);
            check($sformatf("stream_cnt%0d", k), bus.count, 64'(exp_cnt[k]));
            tick();
        end
        enq(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        check("stream_head_next", bus.iss_ctrl, 64'h24);
        tick();
        tick();
        tick();
        check("stream_drained", bus.count, 0);
        bus.iss_ready = 5'b11111;

        // WAW on x7
        enq(1'b1, 3'd2, 5'd0, 5'd0, 5'd7, 1'b1, 64'h71);
        tick();
        enq(1'b1, 3'd1, 5'd0, 5'd0, 5'd7, 1'b1, 64'h72);
        tick();
        enq(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        #1;
        check("waw_busy7", bus.busy, 32'h80);
        check("waw_stall", bus.stall_hazard, 1);
        check("waw_blocked", bus.iss_valid, 0);
        wb_add(2, 5'd7);
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        check("waw_wb_issue", bus.iss_valid, 5'b00010);
        tick();
        wb_clear();
        #1;
        check("waw_set_wins", bus.busy, 32'h80);
        check("waw_count", bus.count, 0);
`else
        check("waw_wb_issue", bus.iss_valid, 0);
        tick();
        wb_clear();
        #1;
        check("waw_busy_clear", bus.busy, 0);
        check("waw_issue_late", bus.iss_valid, 5'b00010);
        tick();
        check("waw_busy_reset", bus.busy, 32'h80);
`endif
        wb_add(1, 5'd7);
        tick();
        wb_clear();
        #1;
        check("waw_final", bus.busy, 0);

        // Flush with an issued x9 writer and two dependent entries queued
        enq(1'b1, 3'd2, 5'd0, 5'd0, 5'd9, 1'b1, 64'h91);
        tick();
        enq(1'b1, 3'd0, 5'd9, 5'd0, 5'd10, 1'b1, 64'hA0);
        tick();
        enq(1'b1, 3'd0, 5'd9, 5'd0, 5'd11, 1'b1, 64'hB0);
        tick();
        enq(1'b1, 3'd4, 5'd0, 5'd0, 5'd0, 1'b0, 64'hC0);
        bus.flush = 1'b1;
        #1;
        check("flush_pre_count", bus.count, 2);
        check("flush_iss_valid", bus.iss_valid, 0);
        check("flush_stall", bus.stall_hazard, 0);
        tick();
        bus.flush = 1'b0;
        enq(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        #1;
        check("flush_count", bus.count, 0);
        check("flush_idle", bus.iss_valid, 0);
        check("flush_busy9", bus.busy, 32'h200);
        wb_add(2, 5'd9);
        tick();
        wb_clear();
        #1;
        check("flush_wb9", bus.busy, 0);

        // Two lanes completing the same rd
        enq(1'b1, 3'd0, 5'd0, 5'd0, 5'd4, 1'b1, 64'h44);
        tick();
        enq(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        tick();
        check("dup_busy4", bus.busy, 32'h10);
        wb_add(0, 5'd4);
        wb_add(3, 5'd4);
        tick();
        wb_clear();
        #1;
        check("dup_clear", bus.busy, 0);

        // Asynchronous reset mid-operation
        bus.iss_ready = '0;
        enq(1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'hEE);
        tick();
        tick();
        enq(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        #1;
        check("mid_count", bus.count, 2);
        RST = 1'b1;
        #1;
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_ready", bus.enq_ready, 1);
        check("mid_rst_iss", bus.iss_valid, 0);
        tick();
        RST = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
